// File: rtl/pwm_defs.sv
// Shared register map for the multi-channel PWM peripheral.
package pwm_defs;

    // Global register word addresses.
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_EVT    = 8'h02;
    localparam logic [7:0] ADDR_IRQ_EN = 8'h03;
    localparam logic [7:0] ADDR_PRESC  = 8'h04;

    // Per-channel register window: CH_BASE + CH_STRIDE*k + offset.
    localparam logic [7:0] CH_BASE     = 8'h10;
    localparam logic [7:0] CH_STRIDE   = 8'h04;

    // Register offsets inside one channel window.
    typedef enum logic [1:0] {
        OFS_PER  = 2'd0,
        OFS_DUTY = 2'd1,
        OFS_STEP = 2'd2,
        OFS_DACT = 2'd3
    } ch_ofs_e;

endpackage

// File: rtl/pwm_canal.sv
// One PWM channel: period counter, shadowed period/duty, per-period duty ramp.
module pwm_canal #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          en,
    input  logic [DW-1:0] period,
    input  logic [DW-1:0] duty_tgt,
    input  logic [DW-1:0] step,
    output logic          pwm,
    output logic          pend,
    output logic [DW-1:0] duty_act,
    output logic          at_target
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] per_act_q, per_act_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic          pwm_q, pwm_d;
    logic          wrap_s;

    // Move cur toward tgt by at most stp without overshoot; stp==0 jumps straight to tgt.
    function automatic logic [DW-1:0] ramp_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt,
                                                  input logic [DW-1:0] stp);
        logic [DW-1:0] res;
        if (stp == {DW{1'b0}}) begin
            res = tgt;
        end else if (tgt >= cur) begin
            res = (stp < (tgt - cur)) ? (cur + stp) : tgt;
        end else begin
            res = (stp < (cur - tgt)) ? (cur - stp) : tgt;
        end
        return res;
    endfunction

    assign wrap_s = tick && en && (per_act_q != {DW{1'b0}}) &&
                    (cnt_q == (per_act_q - DW'(1)));

    // Counter advance, shadow-to-active transfer at period end, and compare.
    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        pwm_d      = 1'b0;
        if (!en) begin
            // Idle channel tracks its targets so it starts without a ramp.
            cnt_d      = {DW{1'b0}};
            per_act_d  = period;
            duty_act_d = duty_tgt;
        end else if (per_act_q == {DW{1'b0}}) begin
            // Parked on a zero period until a non-zero PERIOD is written.
            cnt_d     = {DW{1'b0}};
            per_act_d = period;
        end else begin
            pwm_d = (cnt_q < duty_act_q);
            if (wrap_s) begin
                cnt_d      = {DW{1'b0}};
                per_act_d  = period;
                duty_act_d = ramp_toward(duty_act_q, duty_tgt, step);
            end else if (tick) begin
                cnt_d = cnt_q + DW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= {DW{1'b0}};
            per_act_q  <= {DW{1'b0}};
            duty_act_q <= {DW{1'b0}};
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm       = pwm_q;
    assign pend      = wrap_s;
    assign duty_act  = duty_act_q;
    assign at_target = (duty_act_q == duty_tgt);

endmodule

// File: rtl/peripheral_pwm_multicanal.sv
// Memory-mapped multi-channel PWM peripheral: bus decode, global registers,
// prescaler, read mux and one pwm_canal per channel.
module peripheral_pwm_multicanal
    import pwm_defs::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  d_in,
    input  logic           cs,
    input  logic [AW-1:0]  addr,
    input  logic           rd,
    input  logic           wr,
    output logic [DW-1:0]  d_out,
    output logic [NCH-1:0] pwm_out,
    output logic           irq
);

    localparam logic [AW-1:0] A_CTRL   = AW'(ADDR_CTRL);
    localparam logic [AW-1:0] A_STATUS = AW'(ADDR_STATUS);
    localparam logic [AW-1:0] A_EVT    = AW'(ADDR_EVT);
    localparam logic [AW-1:0] A_IRQ_EN = AW'(ADDR_IRQ_EN);
    localparam logic [AW-1:0] A_PRESC  = AW'(ADDR_PRESC);
    localparam logic [AW-1:0] A_CH_LO  = AW'(CH_BASE);
    localparam int            CH_SPAN  = int'(CH_STRIDE) * NCH;

    logic [NCH-1:0] ctrl_q, ctrl_d, evt_q, evt_d, irq_en_q, irq_en_d, evt_clr_s;
    logic [DW-1:0]  presc_q, presc_d, pcnt_q, pcnt_d, dout_q, rdata_s;
    logic [DW-1:0]  period_q [NCH];
    logic [DW-1:0]  period_d [NCH];
    logic [DW-1:0]  duty_q   [NCH];
    logic [DW-1:0]  duty_d   [NCH];
    logic [DW-1:0]  step_q   [NCH];
    logic [DW-1:0]  step_d   [NCH];
    logic [DW-1:0]  dact_s   [NCH];
    logic [NCH-1:0] pend_s, at_tgt_s, pwm_s;
    logic           irq_q, irq_d, tick_s, wr_s, rd_s, ch_hit_s;
    logic [AW-1:0]  ch_off_s;
    logic [AW-3:0]  ch_sel_s;

    assign wr_s     = cs && wr;
    assign rd_s     = cs && rd;
    assign ch_off_s = addr - A_CH_LO;
    assign ch_sel_s = ch_off_s[AW-1:2];
    assign ch_hit_s = (addr >= A_CH_LO) && (int'(ch_off_s) < CH_SPAN);
    assign tick_s   = (pcnt_q >= presc_q);
    assign pcnt_d   = tick_s ? {DW{1'b0}} : (pcnt_q + DW'(1));

    // Bus write decode, W1C event merge (set beats clear) and interrupt next-state.
    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        presc_d   = presc_q;
        evt_clr_s = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            period_d[k] = period_q[k];
            duty_d[k]   = duty_q[k];
            step_d[k]   = step_q[k];
        end
        if (wr_s) begin
            case (addr)
                A_CTRL:   ctrl_d    = d_in[NCH-1:0];
                A_EVT:    evt_clr_s = d_in[NCH-1:0];
                A_IRQ_EN: irq_en_d  = d_in[NCH-1:0];
                A_PRESC:  presc_d   = d_in;
                default:  ;
            endcase
            for (int k = 0; k < NCH; k++) begin
                if (ch_hit_s && (ch_sel_s == (AW-2)'(k))) begin
                    case (ch_ofs_e'(ch_off_s[1:0]))
                        OFS_PER:  period_d[k] = d_in;
                        OFS_DUTY: duty_d[k]   = d_in;
                        OFS_STEP: step_d[k]   = d_in;
                        default:  ;
                    endcase
                end else begin
                end
            end
        end else begin
        end
        evt_d = (evt_q & ~evt_clr_s) | pend_s;
        irq_d = |(evt_d & irq_en_d);
    end

    // Read mux; unmapped addresses and idle cycles return zero.
    always_comb begin
        rdata_s = {DW{1'b0}};
        if (rd_s) begin
            case (addr)
                A_CTRL:   rdata_s = DW'(ctrl_q);
                A_STATUS: rdata_s = DW'(at_tgt_s);
                A_EVT:    rdata_s = DW'(evt_q);
                A_IRQ_EN: rdata_s = DW'(irq_en_q);
                A_PRESC:  rdata_s = presc_q;
                default:  rdata_s = {DW{1'b0}};
            endcase
            for (int k = 0; k < NCH; k++) begin
                if (ch_hit_s && (ch_sel_s == (AW-2)'(k))) begin
                    case (ch_ofs_e'(ch_off_s[1:0]))
                        OFS_PER:  rdata_s = period_q[k];
                        OFS_DUTY: rdata_s = duty_q[k];
                        OFS_STEP: rdata_s = step_q[k];
                        OFS_DACT: rdata_s = dact_s[k];
                        default:  rdata_s = {DW{1'b0}};
                    endcase
                end else begin
                end
            end
        end else begin
            rdata_s = {DW{1'b0}};
        end
    end

    // Global registers, prescaler, read data and interrupt with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q   <= {NCH{1'b0}};
            evt_q    <= {NCH{1'b0}};
            irq_en_q <= {NCH{1'b0}};
            presc_q  <= {DW{1'b0}};
            pcnt_q   <= {DW{1'b0}};
            dout_q   <= {DW{1'b0}};
            irq_q    <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                period_q[k] <= {DW{1'b0}};
                duty_q[k]   <= {DW{1'b0}};
                step_q[k]   <= {DW{1'b0}};
            end
        end else begin
            ctrl_q   <= ctrl_d;
            evt_q    <= evt_d;
            irq_en_q <= irq_en_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            dout_q   <= rdata_s;
            irq_q    <= irq_d;
            for (int k = 0; k < NCH; k++) begin
                period_q[k] <= period_d[k];
                duty_q[k]   <= duty_d[k];
                step_q[k]   <= step_d[k];
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_canal #(.DW(DW)) u_canal (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_s),
            .en        (ctrl_q[k]),
            .period    (period_q[k]),
            .duty_tgt  (duty_q[k]),
            .step      (step_q[k]),
            .pwm       (pwm_s[k]),
            .pend      (pend_s[k]),
            .duty_act  (dact_s[k]),
            .at_target (at_tgt_s[k])
        );
    end

    assign d_out   = dout_q;
    assign pwm_out = pwm_s;
    assign irq     = irq_q;

endmodule

// File: tb/tb_peripheral_pwm_multicanal.sv
// Directed self-checking bench for peripheral_pwm_multicanal (NCH=4, DW=16, AW=8).
module tb_peripheral_pwm_multicanal;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = 16'h0000;
    logic        cs = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic [3:0]  pwm_out;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int hi;

    peripheral_pwm_multicanal #(.NCH(4), .DW(16), .AW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .cs      (cs),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .d_out   (d_out),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a negedge; the strobe is sampled on the posedge between.
    task automatic wr_reg(input logic [7:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        chk(tag, d_out, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_out[ch]) c++;
            @(negedge clk);
        end
    endtask

    initial begin
        // 1: reset held for two edges while the bus tries to write.
        cs = 1'b1; wr = 1'b1; addr = 8'h00; d_in = 16'h000F;
        @(negedge clk);
        addr = 8'h04; d_in = 16'h0007; rd = 1'b1;
        @(negedge clk);
        rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        chk("rst_pwm", 16'(pwm_out), 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_dout", d_out, 16'h0000);
        rd_chk("rst_ctrl", 8'h00, 16'h0000);
        rd_chk("rst_presc", 8'h04, 16'h0000);
        rd_chk("rst_evt", 8'h02, 16'h0000);
        rd_chk("rst_per0", 8'h10, 16'h0000);
        rd_chk("rst_dact0", 8'h13, 16'h0000);

        // 2: basic PWM on ch0, 3 of 10 high.
        wr_reg(8'h10, 16'd10);
        wr_reg(8'h11, 16'd3);
        wr_reg(8'h00, 16'h0001);
        count_high(0, 10, hi); chk("ch0_hi_a", 16'(hi), 16'd3);
        count_high(0, 10, hi); chk("ch0_hi_b", 16'(hi), 16'd3);
        rd_chk("ch0_evt", 8'h02, 16'h0001);
        rd_chk("ch0_dact", 8'h13, 16'd3);
        idle(1);
        chk("dout_idle", d_out, 16'h0000);
        rd_chk("ch0_per", 8'h10, 16'd10);
        rd_chk("unmapped5", 8'h05, 16'h0000);
        rd_chk("unmapped20", 8'h20, 16'h0000);
        wr_reg(8'h13, 16'h0055);
        rd_chk("ro_dact", 8'h13, 16'd3);
        wr_reg(8'h00, 16'h0000);
        idle(1);
        chk("ch0_off", 16'(pwm_out), 16'h0000);
        wr_reg(8'h02, 16'h000F);
        rd_chk("evt_clr", 8'h02, 16'h0000);

        // 3: shadowing on ch1, duty change lands at the next period.
        wr_reg(8'h14, 16'd8);
        wr_reg(8'h15, 16'd2);
        wr_reg(8'h00, 16'h0002);
        wr_reg(8'h15, 16'd6);
        count_high(1, 8, hi); chk("ch1_cur", 16'(hi), 16'd2);
        count_high(1, 8, hi); chk("ch1_next", 16'(hi), 16'd6);
        wr_reg(8'h00, 16'h0000);

        // 4: ramp on ch2, 0 -> 30 -> 60 -> 80 -> 80.
        wr_reg(8'h18, 16'd100);
        wr_reg(8'h19, 16'd0);
        wr_reg(8'h1A, 16'd30);
        wr_reg(8'h00, 16'h0004);
        wr_reg(8'h19, 16'd80);
        rd_chk("ramp0", 8'h1B, 16'd0);
        rd_chk("stat0", 8'h01, 16'h000B);
        idle(100);
        rd_chk("ramp1", 8'h1B, 16'd30);
        rd_chk("stat1", 8'h01, 16'h000B);
        idle(100);
        rd_chk("ramp2", 8'h1B, 16'd60);
        rd_chk("stat2", 8'h01, 16'h000B);
        idle(100);
        rd_chk("ramp3", 8'h1B, 16'd80);
        rd_chk("stat3", 8'h01, 16'h000F);
        idle(100);
        rd_chk("ramp4", 8'h1B, 16'd80);
        wr_reg(8'h00, 16'h0000);

        // 5a: duty above period gives a constant high.
        wr_reg(8'h11, 16'd12);
        wr_reg(8'h00, 16'h0001);
        idle(1);
        count_high(0, 20, hi); chk("duty_ge_per", 16'(hi), 16'd20);
        wr_reg(8'h00, 16'h0000);

        // 5b: zero period parks the channel low with no events, until PERIOD is written.
        wr_reg(8'h10, 16'd0);
        wr_reg(8'h11, 16'd3);
        wr_reg(8'h02, 16'h000F);
        wr_reg(8'h00, 16'h0001);
        idle(1);
        count_high(0, 20, hi); chk("per0_low", 16'(hi), 16'd0);
        rd_chk("per0_noevt", 8'h02, 16'h0000);
        wr_reg(8'h10, 16'd10);
        idle(1);
        count_high(0, 10, hi); chk("per0_leave", 16'(hi), 16'd3);
        wr_reg(8'h00, 16'h0000);

        // 5c: PRESC=3 stretches the 3/10 waveform to 12/40.
        wr_reg(8'h04, 16'd3);
        rd_chk("presc_rd", 8'h04, 16'd3);
        wr_reg(8'h00, 16'h0001);
        idle(40);
        count_high(0, 40, hi); chk("presc_hi", 16'(hi), 16'd12);
        wr_reg(8'h04, 16'd0);
        wr_reg(8'h00, 16'h0000);

        // 6: EVT/IRQ on ch3 with period 5.
        wr_reg(8'h1C, 16'd5);
        wr_reg(8'h1D, 16'd2);
        wr_reg(8'h02, 16'h000F);
        wr_reg(8'h03, 16'h0008);
        chk("irq_idle", 16'(irq), 16'h0000);
        wr_reg(8'h00, 16'h0008);
        idle(4);
        chk("irq_pre", 16'(irq), 16'h0000);
        idle(1);
        chk("irq_set", 16'(irq), 16'h0001);
        idle(4);
        wr_reg(8'h02, 16'h0008);
        chk("irq_setwins", 16'(irq), 16'h0001);
        rd_chk("evt_setwins", 8'h02, 16'h0008);
        wr_reg(8'h02, 16'h0008);
        chk("irq_clr", 16'(irq), 16'h0000);
        rd_chk("evt_clr3", 8'h02, 16'h0000);

        // 7: reset in the middle of operation.
        idle(3);
        chk("irq_again", 16'(irq), 16'h0001);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_pwm", 16'(pwm_out), 16'h0000);
        chk("mid_rst_irq", 16'(irq), 16'h0000);
        rd_chk("mid_rst_ctrl", 8'h00, 16'h0000);
        rd_chk("mid_rst_ien", 8'h03, 16'h0000);
        rd_chk("mid_rst_per3", 8'h1C, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
